// File: rtl/axi_ram_pkg.sv
// Shared definitions for axi_ram: burst codes, response code, FSM states.
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {WR_IDLE, WR_BURST, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_BURST}          rd_state_t;

  // Byte increment between beats; WRAP and the reserved code step like INCR.
  function automatic logic [7:0] beat_step(input logic [1:0] burst, input logic [2:0] size);
    case (burst)
      BURST_FIXED:             beat_step = 8'd0;
      BURST_INCR, BURST_WRAP:  beat_step = 8'd1 << size;
      default:                 beat_step = 8'd1 << size;
    endcase
  endfunction

endpackage

// File: rtl/axi_ram_mem.sv
// Byte-enable simple dual-port RAM: one write port, one registered read port.
// A read and write to the same word on one edge returns the old contents.
module axi_ram_mem
  import axi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int WORD_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [WORD_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  re,
  input  logic [WORD_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** WORD_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-lane writes; array contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Registered read; holds its value when no read is requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_ram.sv
// AXI4 slave RAM with independent write and read burst engines.
// Optional: define AXI_RAM_PIPELINE_OUTPUT_EN to add an R-channel output register.
module axi_ram
  import axi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int WORD_WIDTH = ADDR_WIDTH - ADDR_LSB;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                  ready_en;
  logic                  aw_fire, w_fire, ar_fire;
  logic [ID_WIDTH-1:0]   wr_id, rd_id;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, rd_addr_mem;
  logic [7:0]            wr_len, wr_cnt, rd_len, rd_cnt;
  logic [2:0]            wr_size, rd_size;
  logic [1:0]            wr_burst, rd_burst;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  core_valid, core_ready, core_last, core_fire;
  logic                  unused_inputs;

  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_wlast};

  // Address-channel readies are held low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_state <= WR_IDLE;
    else      wr_state <= wr_next;
  end

  // Write FSM next state and handshake outputs; burst ends on beat count, not wlast.
  always_comb begin
    wr_next       = wr_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        s_axi_awready = ready_en;
        if (s_axi_awvalid && ready_en) wr_next = WR_BURST;
      end
      WR_BURST: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && (wr_cnt == wr_len)) wr_next = WR_RESP;
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid && s_axi_wready;

  // Write burst context: captured on AW, beat address advanced on each W beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_id <= '0; wr_addr <= '0; wr_len <= '0; wr_cnt <= '0; wr_size <= '0; wr_burst <= '0;
    end else if (aw_fire) begin
      wr_id    <= s_axi_awid;
      wr_addr  <= s_axi_awaddr;
      wr_len   <= s_axi_awlen;
      wr_size  <= s_axi_awsize;
      wr_burst <= s_axi_awburst;
      wr_cnt   <= '0;
    end else if (w_fire) begin
      wr_addr <= wr_addr + ADDR_WIDTH'(beat_step(wr_burst, wr_size));
      wr_cnt  <= wr_cnt + 8'd1;
    end
  end

  assign s_axi_bid   = wr_id;
  assign s_axi_bresp = RESP_OKAY;

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_state <= RD_IDLE;
    else      rd_state <= rd_next;
  end

  // Read FSM next state; the RAM is read on AR acceptance and on every non-final beat
  // handshake, so the RAM output register doubles as the stalled R-data holding register.
  always_comb begin
    rd_next       = rd_state;
    s_axi_arready = 1'b0;
    core_valid    = 1'b0;
    mem_re        = 1'b0;
    rd_addr_mem   = rd_addr;
    case (rd_state)
      RD_IDLE: begin
        s_axi_arready = ready_en;
        if (s_axi_arvalid && ready_en) begin
          rd_next     = RD_BURST;
          mem_re      = 1'b1;
          rd_addr_mem = s_axi_araddr;
        end
      end
      RD_BURST: begin
        core_valid = 1'b1;
        if (core_ready) begin
          if (rd_cnt == rd_len) rd_next = RD_IDLE;
          else                  mem_re  = 1'b1;
        end
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  assign ar_fire   = s_axi_arvalid && s_axi_arready;
  assign core_fire = core_valid && core_ready;
  assign core_last = core_valid && (rd_cnt == rd_len);

  // Read burst context: rd_addr always points at the next beat to fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_id <= '0; rd_addr <= '0; rd_len <= '0; rd_cnt <= '0; rd_size <= '0; rd_burst <= '0;
    end else if (ar_fire) begin
      rd_id    <= s_axi_arid;
      rd_addr  <= s_axi_araddr + ADDR_WIDTH'(beat_step(s_axi_arburst, s_axi_arsize));
      rd_len   <= s_axi_arlen;
      rd_size  <= s_axi_arsize;
      rd_burst <= s_axi_arburst;
      rd_cnt   <= '0;
    end else if (core_fire) begin
      rd_addr <= rd_addr + ADDR_WIDTH'(beat_step(rd_burst, rd_size));
      rd_cnt  <= rd_cnt + 8'd1;
    end
  end

  axi_ram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .STRB_WIDTH(STRB_WIDTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (w_fire),
    .waddr(wr_addr[ADDR_WIDTH-1:ADDR_LSB]),
    .wdata(s_axi_wdata),
    .wstrb(s_axi_wstrb),
    .re   (mem_re),
    .raddr(rd_addr_mem[ADDR_WIDTH-1:ADDR_LSB]),
    .rdata(mem_rdata)
  );

  assign s_axi_rresp = RESP_OKAY;

`ifdef AXI_RAM_PIPELINE_OUTPUT_EN
  logic                  out_valid, out_last;
  logic [ID_WIDTH-1:0]   out_id;
  logic [DATA_WIDTH-1:0] out_data;

  assign core_ready = !out_valid || s_axi_rready;

  // Output register stage; refills in the same cycle it drains for full throughput.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0; out_last <= 1'b0; out_id <= '0; out_data <= '0;
    end else if (core_fire) begin
      out_valid <= 1'b1;
      out_last  <= core_last;
      out_id    <= rd_id;
      out_data  <= mem_rdata;
    end else if (s_axi_rready) begin
      out_valid <= 1'b0;
    end
  end

  assign s_axi_rvalid = out_valid;
  assign s_axi_rlast  = out_valid && out_last;
  assign s_axi_rid    = out_id;
  assign s_axi_rdata  = out_data;
`else
  assign core_ready   = s_axi_rready;
  assign s_axi_rvalid = core_valid;
  assign s_axi_rlast  = core_last;
  assign s_axi_rid    = rd_id;
  assign s_axi_rdata  = mem_rdata;
`endif

endmodule

// File: tb/tb_axi_ram.sv
// Self-checking bench for axi_ram using an expected-beat scoreboard for reads.
module tb_axi_ram;

  logic        clk, rst;
  logic [7:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [15:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awlock, s_axi_arlock;
  logic [3:0]  s_axi_awcache, s_axi_arcache, s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [7:0]  id;
    logic [1:0]  resp;
  } beat_t;

`ifdef AXI_RAM_PIPELINE_OUTPUT_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  int          tests = 0;
  int          fails = 0;
  beat_t       exp_q[$];
  beat_t       got_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_strb_q[$];
  logic [7:0]  got_bid;
  logic [1:0]  got_bresp;
  logic        b_dropped, stall_changed, tail_valid;
  int          first_lat;

  axi_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk(input logic [31:0] d, input logic l, input logic [7:0] id);
    mk = {d, l, id, 2'b00};
  endfunction

  // Drives one write burst from wr_data_q/wr_strb_q; holds bready low b_hold cycles.
  task automatic do_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int b_hold);
    int n;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin tests++; fails++; $display("FAIL aw_timeout awready=%b required=1", s_axi_awready); end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata = wr_data_q[i]; s_axi_wstrb = wr_strb_q[i];
      s_axi_wlast = (i == int'(len)); s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin tests++; fails++; $display("FAIL w_timeout wready=%b required=1", s_axi_wready); end
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    s_axi_bready = (b_hold == 0);
    n = 0;
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin tests++; fails++; $display("FAIL b_timeout bvalid=%b required=1", s_axi_bvalid); end
    b_dropped = 1'b0;
    for (int k = 0; k < b_hold; k++) begin
      @(negedge clk);
      if (!s_axi_bvalid) b_dropped = 1'b1;
    end
    got_bid = s_axi_bid; got_bresp = s_axi_bresp;
    s_axi_bready = 1'b1;
    @(negedge clk);
  endtask

  // Issues one read burst and collects beats into got_q; optional rready stall at one beat.
  task automatic read_burst(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int stall_at, input int stall_len);
    int n, beat;
    logic [31:0] hd;
    logic hl;
    logic [7:0] hi;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin tests++; fails++; $display("FAIL ar_timeout arready=%b required=1", s_axi_arready); end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    first_lat = -1; beat = 0; n = 0; stall_changed = 1'b0;
    while (beat <= int'(len) && n < 300) begin
      if (s_axi_rvalid) begin
        if (first_lat < 0) first_lat = n + 1;
        if (beat == stall_at && stall_len > 0) begin
          s_axi_rready = 1'b0;
          hd = s_axi_rdata; hl = s_axi_rlast; hi = s_axi_rid;
          repeat (stall_len) begin
            @(negedge clk);
            if (!s_axi_rvalid || s_axi_rdata !== hd || s_axi_rlast !== hl || s_axi_rid !== hi)
              stall_changed = 1'b1;
          end
          s_axi_rready = 1'b1;
        end
        got_q.push_back({s_axi_rdata, s_axi_rlast, s_axi_rid, s_axi_rresp});
        beat++;
      end
      @(negedge clk);
      n++;
    end
    if (beat <= int'(len)) begin
      tests++; fails++;
      $display("FAIL r_timeout beats=%0d required=%0d", beat, int'(len) + 1);
    end
    tail_valid = s_axi_rvalid;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0; s_axi_wlast = 0;
    s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
    s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0; s_axi_arburst = 0;
    s_axi_awlock = 0; s_axi_awcache = 0; s_axi_awprot = 0;
    s_axi_arlock = 1; s_axi_arcache = 4'hF; s_axi_arprot = 3'h7;
    s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_bready = 1; s_axi_rready = 1;
    repeat (3) @(negedge clk);
    tests++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl aw/w/b/ar/rv/rl=%b required=000000",
               {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast});
    end
    tests++;
    if ({s_axi_bid, s_axi_rid, s_axi_rdata} !== 48'h0) begin
      fails++;
      $display("FAIL reset_data bid=%h rid=%h rdata=%h required=0", s_axi_bid, s_axi_rid, s_axi_rdata);
    end
    rst = 1'b1;
    tests++;
    if ({s_axi_awready, s_axi_arready} !== 2'b00) begin
      fails++; $display("FAIL release_early aw/ar=%b required=00", {s_axi_awready, s_axi_arready});
    end
    @(negedge clk);
    tests++;
    if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
      fails++; $display("FAIL release_ready aw/ar=%b required=11", {s_axi_awready, s_axi_arready});
    end
  endtask

  task automatic test_single_write();
    beat_t e, g;
    wr_data_q = '{32'hDEADBEEF}; wr_strb_q = '{4'hF};
    do_write(8'h05, 16'h0010, 8'd0, 3'd2, 2'b01, 0);
    tests++;
    if (got_bid !== 8'h05) begin fails++; $display("FAIL single_bid got=%h required=05", got_bid); end
    tests++;
    if (got_bresp !== 2'b00) begin fails++; $display("FAIL single_bresp got=%b required=00", got_bresp); end
    exp_q.push_back(mk(32'hDEADBEEF, 1'b1, 8'h09));
    read_burst(8'h09, 16'h0010, 8'd0, 3'd2, 2'b01, -1, 0);
    tests++;
    if (first_lat !== EXP_LAT) begin fails++; $display("FAIL read_latency got=%0d required=%0d", first_lat, EXP_LAT); end
    tests++;
    if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL single_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
      if (g !== e) begin fails++; $display("FAIL single_beat got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_incr_burst();
    beat_t e, g;
    wr_data_q = '{32'd1, 32'd2, 32'd3, 32'd4}; wr_strb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(8'h03, 16'h0100, 8'd3, 3'd2, 2'b01, 0);
    tests++;
    if (got_bresp !== 2'b00) begin fails++; $display("FAIL incr_bresp got=%b required=00", got_bresp); end
    for (int i = 1; i <= 4; i++) exp_q.push_back(mk(32'(i), i == 4, 8'h21));
    read_burst(8'h21, 16'h0100, 8'd3, 3'd2, 2'b01, -1, 0);
    tests++;
    if (tail_valid !== 1'b0) begin fails++; $display("FAIL incr_tail rvalid=%b required=0", tail_valid); end
    tests++;
    if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL incr_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
      if (g !== e) begin fails++; $display("FAIL incr_beat got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_partial_strobe();
    beat_t e, g;
    wr_data_q = '{32'h0}; wr_strb_q = '{4'hF};
    do_write(8'h01, 16'h0000, 8'd0, 3'd2, 2'b01, 0);
    wr_data_q = '{32'hAABBCCDD}; wr_strb_q = '{4'h5};
    do_write(8'h02, 16'h0000, 8'd0, 3'd2, 2'b01, 0);
    exp_q.push_back(mk(32'h00BB00DD, 1'b1, 8'h30));
    read_burst(8'h30, 16'h0002, 8'd0, 3'd2, 2'b01, -1, 0);
    tests++;
    if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL strobe_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
      if (g !== e) begin fails++; $display("FAIL strobe_beat got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_fixed_burst();
    beat_t e, g;
    wr_data_q = '{32'h55555555}; wr_strb_q = '{4'hF};
    do_write(8'h07, 16'h0024, 8'd0, 3'd2, 2'b01, 0);
    wr_data_q = '{32'd7, 32'd8, 32'd9}; wr_strb_q = '{4'hF, 4'hF, 4'hF};
    do_write(8'h08, 16'h0020, 8'd2, 3'd2, 2'b00, 0);
    tests++;
    if (got_bid !== 8'h08) begin fails++; $display("FAIL fixed_bid got=%h required=08", got_bid); end
    exp_q.push_back(mk(32'd9, 1'b1, 8'h40));
    read_burst(8'h40, 16'h0020, 8'd0, 3'd2, 2'b01, -1, 0);
    exp_q.push_back(mk(32'h55555555, 1'b1, 8'h41));
    read_burst(8'h41, 16'h0024, 8'd0, 3'd2, 2'b01, -1, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(32'd9, i == 2, 8'h42));
    read_burst(8'h42, 16'h0020, 8'd2, 3'd2, 2'b00, -1, 0);
    tests++;
    if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL fixed_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
      if (g !== e) begin fails++; $display("FAIL fixed_beat got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_addr_step();
    beat_t e, g;
    // INCR across the top of the address space wraps to 0x0000.
    wr_data_q = '{32'hA0A0A0A0, 32'hB0B0B0B0}; wr_strb_q = '{4'hF, 4'hF};
    do_write(8'h11, 16'hFFFC, 8'd1, 3'd2, 2'b01, 0);
    exp_q.push_back(mk(32'hA0A0A0A0, 1'b0, 8'h50));
    exp_q.push_back(mk(32'hB0B0B0B0, 1'b1, 8'h50));
    read_burst(8'h50, 16'hFFFC, 8'd1, 3'd2, 2'b01, -1, 0);
    exp_q.push_back(mk(32'hB0B0B0B0, 1'b1, 8'h51));
    read_burst(8'h51, 16'h0000, 8'd0, 3'd2, 2'b01, -1, 0);
    // size=1 steps two bytes: beats land on words 0x300,0x300,0x304,0x304.
    wr_data_q = '{32'd1, 32'd2, 32'd3, 32'd4}; wr_strb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(8'h12, 16'h0300, 8'd3, 3'd1, 2'b01, 0);
    exp_q.push_back(mk(32'd2, 1'b0, 8'h52));
    exp_q.push_back(mk(32'd4, 1'b1, 8'h52));
    read_burst(8'h52, 16'h0300, 8'd1, 3'd2, 2'b01, -1, 0);
    // WRAP write and reserved-code read both step like INCR.
    wr_data_q = '{32'hC1C1C1C1, 32'hC2C2C2C2}; wr_strb_q = '{4'hF, 4'hF};
    do_write(8'h13, 16'h0200, 8'd1, 3'd2, 2'b10, 0);
    exp_q.push_back(mk(32'hC1C1C1C1, 1'b0, 8'h53));
    exp_q.push_back(mk(32'hC2C2C2C2, 1'b1, 8'h53));
    read_burst(8'h53, 16'h0200, 8'd1, 3'd2, 2'b11, -1, 0);
    tests++;
    if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL step_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
      if (g !== e) begin fails++; $display("FAIL step_beat got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    beat_t e, g;
    for (int i = 1; i <= 4; i++) exp_q.push_back(mk(32'(i), i == 4, 8'h60));
    read_burst(8'h60, 16'h0100, 8'd3, 3'd2, 2'b01, 1, 5);
    tests++;
    if (stall_changed !== 1'b0) begin fails++; $display("FAIL r_stall_hold changed=%b required=0", stall_changed); end
    tests++;
    if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL bp_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
      if (g !== e) begin fails++; $display("FAIL bp_beat got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    wr_data_q = '{32'h600D600D}; wr_strb_q = '{4'hF};
    do_write(8'h61, 16'h0600, 8'd0, 3'd2, 2'b01, 5);
    tests++;
    if (b_dropped !== 1'b0) begin fails++; $display("FAIL b_stall_hold dropped=%b required=0", b_dropped); end
    tests++;
    if (got_bid !== 8'h61) begin fails++; $display("FAIL b_stall_bid got=%h required=61", got_bid); end
  endtask

  task automatic test_rw_collision();
    beat_t e, g;
    int n;
    wr_data_q = '{32'h11111111}; wr_strb_q = '{4'hF};
    do_write(8'h70, 16'h0400, 8'd0, 3'd2, 2'b01, 0);
    s_axi_awid = 8'h71; s_axi_awaddr = 16'h0400; s_axi_awlen = 8'd0;
    s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wdata = 32'h22222222; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_arid = 8'h72; s_axi_araddr = 16'h0400; s_axi_arlen = 8'd0;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    tests++;
    if ({s_axi_wready, s_axi_arready} !== 2'b11) begin
      fails++; $display("FAIL collide_setup w/ar ready=%b required=11", {s_axi_wready, s_axi_arready});
    end
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 10) begin @(negedge clk); n++; end
    tests++;
    if (s_axi_rdata !== 32'h11111111) begin fails++; $display("FAIL collide_old got=%h required=11111111", s_axi_rdata); end
    repeat (4) @(negedge clk);
    exp_q.push_back(mk(32'h22222222, 1'b1, 8'h73));
    read_burst(8'h73, 16'h0400, 8'd0, 3'd2, 2'b01, -1, 0);
    tests++;
    if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL collide_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
      if (g !== e) begin fails++; $display("FAIL collide_new got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    beat_t e, g;
    int n;
    s_axi_awid = 8'h80; s_axi_awaddr = 16'h0700; s_axi_awlen = 8'd7;
    s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wdata = 32'hEEEEEEEE; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    repeat (2) @(negedge clk);
    s_axi_wvalid = 1'b0;
    s_axi_rready = 1'b0;
    s_axi_arid = 8'h81; s_axi_araddr = 16'h0100; s_axi_arlen = 8'd3;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast} !== 6'b0) begin
      fails++;
      $display("FAIL midreset_ctrl aw/w/b/ar/rv/rl=%b required=000000",
               {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast});
    end
    tests++;
    if ({s_axi_bid, s_axi_rid, s_axi_rdata} !== 48'h0) begin
      fails++;
      $display("FAIL midreset_data bid=%h rid=%h rdata=%h required=0", s_axi_bid, s_axi_rid, s_axi_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    s_axi_rready = 1'b1;
    @(negedge clk);
    tests++;
    if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid} !== 5'b11000) begin
      fails++;
      $display("FAIL midreset_idle aw/ar/w/b/rv=%b required=11000",
               {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid});
    end
    wr_data_q = '{32'h12345678}; wr_strb_q = '{4'hF};
    do_write(8'h82, 16'h0710, 8'd0, 3'd2, 2'b01, 0);
    tests++;
    if (got_bid !== 8'h82) begin fails++; $display("FAIL post_reset_bid got=%h required=82", got_bid); end
    exp_q.push_back(mk(32'h12345678, 1'b1, 8'h83));
    read_burst(8'h83, 16'h0710, 8'd0, 3'd2, 2'b01, -1, 0);
    exp_q.push_back(mk(32'hDEADBEEF, 1'b1, 8'h84));
    read_burst(8'h84, 16'h0010, 8'd0, 3'd2, 2'b01, -1, 0);
    tests++;
    if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL post_reset_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
      if (g !== e) begin fails++; $display("FAIL post_reset_beat got=%h required=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr_burst();
    test_partial_strobe();
    test_fixed_burst();
    test_addr_step();
    test_backpressure();
    test_rw_collision();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
